// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - byte-serial 32-bit ALU that reads and writes a register file over four phases
module serial_alu (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] op,
   input  logic [7:0] rs1_dat,
   input  logic [7:0] rs2_dat,
   output logic [1:0] phase,
   output logic [7:0] rd_dat,
   output logic       rd_we,
   output logic       busy,
   output logic       done,
   output logic       eq,
   output logic       lt,
   output logic       ltu
);
   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SLT  = 3'd5;
   localparam logic [2:0] OP_SLTU = 3'd6;

   state_t      state, state_next;
   logic [2:0]  op_q;
   logic [31:0] buffer;
   logic        add_carry, cmp_carry, eq_acc;
   logic        pend_eq, pend_lt, pend_ltu;
   logic [8:0]  add_sum, cmp_sum;
   logic        fin_eq, fin_lt, fin_ltu;
   logic [7:0]  res_byte;

   // compare chain A + ~B + carry runs for every op so the flags are always valid
   assign add_sum = {1'b0, rs1_dat} + {1'b0, rs2_dat} + {8'h00, add_carry};
   assign cmp_sum = {1'b0, rs1_dat} + {1'b0, ~rs2_dat} + {8'h00, cmp_carry};
   assign fin_eq  = eq_acc & (rs1_dat == rs2_dat);
   assign fin_ltu = ~cmp_sum[8];
   assign fin_lt  = (rs1_dat[7] != rs2_dat[7]) ? rs1_dat[7] : fin_ltu;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      rd_we      = 1'b0;
      rd_dat     = 8'h00;
      case (state)
         IDLE: if (start) state_next = EXEC;
         EXEC: begin
            busy = 1'b1;
            if (phase == 2'd3) state_next = WB;
         end
         WB: begin
            busy   = 1'b1;
            rd_we  = 1'b1;
            rd_dat = buffer[{phase, 3'b000} +: 8];
            if (phase == 2'd3) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      res_byte = 8'h00;
      case (op_q)
         OP_ADD:  res_byte = add_sum[7:0];
         OP_SUB:  res_byte = cmp_sum[7:0];
         OP_AND:  res_byte = rs1_dat & rs2_dat;
         OP_OR:   res_byte = rs1_dat | rs2_dat;
         OP_XOR:  res_byte = rs1_dat ^ rs2_dat;
         OP_SLT:  res_byte = 8'h00;
         OP_SLTU: res_byte = 8'h00;
         default: res_byte = rs2_dat;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase     <= 2'd0;
         op_q      <= 3'd0;
         buffer    <= 32'h0;
         add_carry <= 1'b0;
         cmp_carry <= 1'b0;
         eq_acc    <= 1'b0;
         pend_eq   <= 1'b0;
         pend_lt   <= 1'b0;
         pend_ltu  <= 1'b0;
         done      <= 1'b0;
         eq        <= 1'b0;
         lt        <= 1'b0;
         ltu       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               op_q      <= op;
               add_carry <= 1'b0;
               cmp_carry <= 1'b1;
               eq_acc    <= 1'b1;
               phase     <= 2'd0;
            end
            EXEC: begin
               buffer[{phase, 3'b000} +: 8] <= res_byte;
               add_carry <= add_sum[8];
               cmp_carry <= cmp_sum[8];
               eq_acc    <= fin_eq;
               phase     <= phase + 2'd1;
               if (phase == 2'd3) begin
                  pend_eq  <= fin_eq;
                  pend_lt  <= fin_lt;
                  pend_ltu <= fin_ltu;
                  // set-less-than results only exist once the top byte is compared
                  if (op_q == OP_SLT)  buffer[7:0] <= {7'b0, fin_lt};
                  if (op_q == OP_SLTU) buffer[7:0] <= {7'b0, fin_ltu};
               end
            end
            WB: begin
               phase <= phase + 2'd1;
               if (phase == 2'd3) begin
                  done <= 1'b1;
                  eq   <= pend_eq;
                  lt   <= pend_lt;
                  ltu  <= pend_ltu;
               end
            end
            default: phase <= 2'd0;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - randomized self-checking bench for serial_alu against a word-level model
module tb_serial_alu;
   logic       clk = 1'b0;
   logic       rst, start;
   logic [2:0] op;
   logic [7:0] rs1_dat, rs2_dat;
   logic [1:0] phase;
   logic [7:0] rd_dat;
   logic       rd_we, busy, done, eq, lt, ltu;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] a_cur = 32'h0;
   logic [31:0] b_cur = 32'h0;
   logic [7:0]  junk1 = 8'h00;
   logic [7:0]  junk2 = 8'h00;

   always #5 clk = ~clk;

   serial_alu dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .rs1_dat(rs1_dat), .rs2_dat(rs2_dat), .phase(phase),
      .rd_dat(rd_dat), .rd_we(rd_we), .busy(busy), .done(done),
      .eq(eq), .lt(lt), .ltu(ltu)
   );

   // register file read ports: real operand bytes only while executing, noise otherwise
   always @(negedge clk) begin
      junk1 = 8'($urandom);
      junk2 = 8'($urandom);
   end

   always_comb begin
      if (busy && !rd_we) begin
         rs1_dat = a_cur[{phase, 3'b000} +: 8];
         rs2_dat = b_cur[{phase, 3'b000} +: 8];
      end else begin
         rs1_dat = junk1;
         rs2_dat = junk2;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      case (o)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return {31'b0, $signed(a) < $signed(b)};
         3'd6:    return {31'b0, a < b};
         default: return b;
      endcase
   endfunction

   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int spur, input bit check_gap);
      logic [31:0] res = 32'h0;
      int  writes = 0;
      int  lat = 0;
      bit  stray_dat = 0, order_ok = 1, busy_ok = 1;
      a_cur = a;
      b_cur = b;
      op    = o;
      start = 1'b1;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (n == spur) begin
            start = 1'b1;
            op    = ~o;
         end
         if (rd_we) begin
            if (phase != writes[1:0]) order_ok = 0;
            res[{phase, 3'b000} +: 8] = rd_dat;
            writes++;
         end else if (rd_dat != 8'h00) begin
            stray_dat = 1;
         end
         if (n <= 8 && !busy) busy_ok = 0;
         if (done && busy) busy_ok = 0;
         if (done) lat = n;
      end
      start = 1'b0;
      check("latency",   lat, 9);
      check("writes",    writes, 4);
      check("result",    res, model_res(o, a, b));
      check("eq",        {31'b0, eq},  {31'b0, a == b});
      check("lt",        {31'b0, lt},  {31'b0, $signed(a) < $signed(b)});
      check("ltu",       {31'b0, ltu}, {31'b0, a < b});
      check("wr_order",  {31'b0, order_ok}, 32'd1);
      check("rd_dat_off", {31'b0, stray_dat}, 32'd0);
      check("busy",      {31'b0, busy_ok}, 32'd1);
      if (check_gap) begin
         @(negedge clk);
         check("done_pulse", {31'b0, done}, 32'd0);
         check("idle_busy",  {31'b0, busy}, 32'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      bit          saw_done;
      bit          hit;
      rst   = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      repeat (2) @(negedge clk);
      check("rst_phase", {30'b0, phase}, 32'd0);
      check("rst_out", {21'b0, rd_we, rd_dat, busy, done}, 32'd0);
      check("rst_flags", {29'b0, eq, lt, ltu}, 32'd0);
      start = 1'b1;
      @(negedge clk);
      check("rst_prio", {31'b0, busy}, 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);

      do_op(3'd0, 32'h0000_00FF, 32'h0000_0001, 0, 1);
      do_op(3'd1, 32'h0000_0000, 32'h0000_0001, 0, 1);
      do_op(3'd5, 32'h8000_0000, 32'h0000_0001, 0, 1);
      do_op(3'd6, 32'h8000_0000, 32'h0000_0001, 0, 1);
      do_op(3'd4, 32'h1234_5678, 32'h1234_5678, 0, 1);

      // spurious start mid-operation, then a start in the done cycle
      do_op(3'd0, 32'hDEAD_BEEF, 32'h0123_4567, 3, 0);
      do_op(3'd7, 32'h0000_0000, 32'hCAFE_F00D, 0, 1);

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ 32'h8000_0000;
            2:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
            default: rb = $urandom;
         endcase
         do_op(ro, ra, rb, (i % 5 == 0) ? int'($urandom_range(1, 8)) : 0, bit'($urandom_range(0, 1)));
      end

      // abort in the middle of write-back
      a_cur = 32'h1111_1111;
      b_cur = 32'h2222_2222;
      op    = 3'd0;
      start = 1'b1;
      hit   = 0;
      for (int n = 0; n < 12 && !hit; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (rd_we && phase == 2'd1) hit = 1;
      end
      check("abort_reached_wb1", {31'b0, hit}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_phase", {30'b0, phase}, 32'd0);
      check("abort_rd_we", {31'b0, rd_we}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_flags", {29'b0, eq, lt, ltu}, 32'd0);
      saw_done = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (done || rd_we) saw_done = 1;
      end
      check("abort_no_done", {31'b0, saw_done}, 32'd0);

      do_op(3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
